// File: rtl/euler_frame_rx.sv
// Positional decoder for the 10-byte Euler telemetry frame ('S' Y Y ' ' R R ' ' P P '\n').
// Publishes yaw/roll/pitch atomically on a good frame and tracks errors and staleness.
module euler_frame_rx #(
    parameter int TIMEOUT_CLKS = 10_000,
    parameter int STALE_CLKS   = 7_500_000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_RX_DV,
    input  logic [7:0]         i_RX_Byte,
    output logic signed [15:0] o_Yaw,
    output logic signed [15:0] o_Roll,
    output logic signed [15:0] o_Pitch,
    output logic               o_Frame_Valid,
    output logic [7:0]         o_Err_Count,
    output logic               o_Stale
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int SW = $clog2(STALE_CLKS + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CLKS);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    localparam logic [7:0] SYNC_B = 8'h53;
    localparam logic [7:0] SEP_B  = 8'h20;
    localparam logic [7:0] EOF_B  = 8'h0A;

    logic [0:0]         state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic [SW-1:0]      stale_cnt_q, stale_cnt_d;
    logic               stale_q, stale_d;
    logic [7:0]         err_q, err_d;
    logic               fv_q, fv_d;
    logic signed [15:0] yaw_sh_q, yaw_sh_d;
    logic signed [15:0] roll_sh_q, roll_sh_d;
    logic signed [15:0] pitch_sh_q, pitch_sh_d;
    logic signed [15:0] yaw_q, yaw_d;
    logic signed [15:0] roll_q, roll_d;
    logic signed [15:0] pitch_q, pitch_d;
    logic               accept;
    logic               marker_err;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        to_cnt_d    = to_cnt_q;
        stale_cnt_d = stale_cnt_q;
        stale_d     = stale_q;
        err_d       = err_q;
        fv_d        = 1'b0;
        yaw_sh_d    = yaw_sh_q;
        roll_sh_d   = roll_sh_q;
        pitch_sh_d  = pitch_sh_q;
        yaw_d       = yaw_q;
        roll_d      = roll_q;
        pitch_d     = pitch_q;
        accept      = 1'b0;
        marker_err  = 1'b0;

        if (state_q == ST_RECV) begin
            if (i_RX_DV) begin
                to_cnt_d = '0;
                idx_d    = idx_q + 4'd1;
                case (idx_q)
                    4'd1:       yaw_sh_d[15:8]   = i_RX_Byte;
                    4'd2:       yaw_sh_d[7:0]    = i_RX_Byte;
                    4'd4:       roll_sh_d[15:8]  = i_RX_Byte;
                    4'd5:       roll_sh_d[7:0]   = i_RX_Byte;
                    4'd7:       pitch_sh_d[15:8] = i_RX_Byte;
                    4'd8:       pitch_sh_d[7:0]  = i_RX_Byte;
                    4'd3, 4'd6: marker_err = (i_RX_Byte != SEP_B);
                    4'd9: begin
                        accept     = (i_RX_Byte == EOF_B);
                        marker_err = (i_RX_Byte != EOF_B);
                    end
                    default: ;
                endcase
                if (accept) begin
                    yaw_d   = yaw_sh_q;
                    roll_d  = roll_sh_q;
                    pitch_d = pitch_sh_q;
                    fv_d    = 1'b1;
                    state_d = ST_HUNT;
                    idx_d   = 4'd0;
                end
                // A bad marker that is itself a sync byte restarts the frame in place.
                if (marker_err) begin
                    err_d = sat_inc8(err_q);
                    if (i_RX_Byte == SYNC_B) begin
                        idx_d = 4'd1;
                    end else begin
                        state_d = ST_HUNT;
                        idx_d   = 4'd0;
                    end
                end
            end else if (to_cnt_q == TO_LAST) begin
                state_d  = ST_HUNT;
                idx_d    = 4'd0;
                to_cnt_d = '0;
                err_d    = sat_inc8(err_q);
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
            if (i_RX_DV && (i_RX_Byte == SYNC_B)) begin
                state_d = ST_RECV;
                idx_d   = 4'd1;
            end
        end

        if (accept) begin
            stale_cnt_d = '0;
            stale_d     = 1'b0;
        end else begin
            if (stale_cnt_q != STALE_MAX) begin
                stale_cnt_d = stale_cnt_q + SW'(1);
            end
            if (stale_cnt_d == STALE_MAX) begin
                stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q     <= ST_HUNT;
            idx_q       <= 4'd0;
            to_cnt_q    <= '0;
            stale_cnt_q <= '0;
            stale_q     <= 1'b1;
            err_q       <= 8'd0;
            fv_q        <= 1'b0;
            yaw_q       <= '0;
            roll_q      <= '0;
            pitch_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            to_cnt_q    <= to_cnt_d;
            stale_cnt_q <= stale_cnt_d;
            stale_q     <= stale_d;
            err_q       <= err_d;
            fv_q        <= fv_d;
            yaw_q       <= yaw_d;
            roll_q      <= roll_d;
            pitch_q     <= pitch_d;
        end
    end

    // Shadows are always fully rewritten before publication, so they carry no reset.
    always_ff @(posedge i_Clk) begin
        yaw_sh_q   <= yaw_sh_d;
        roll_sh_q  <= roll_sh_d;
        pitch_sh_q <= pitch_sh_d;
    end

    assign o_Yaw         = yaw_q;
    assign o_Roll        = roll_q;
    assign o_Pitch       = pitch_q;
    assign o_Frame_Valid = fv_q;
    assign o_Err_Count   = err_q;
    assign o_Stale       = stale_q;

endmodule

// File: tb/tb_euler_frame_rx.sv
// Scoreboard bench for euler_frame_rx: frames push expected values, a negedge monitor
// pops and compares on every o_Frame_Valid pulse.
module tb_euler_frame_rx;

    logic               clk;
    logic               rst_l;
    logic               rx_dv;
    logic [7:0]         rx_byte;
    logic signed [15:0] yaw, roll, pitch;
    logic               fv;
    logic [7:0]         err;
    logic               stale;

    typedef struct {
        logic [15:0] y;
        logic [15:0] r;
        logic [15:0] p;
        logic [7:0]  e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_err;

    euler_frame_rx #(
        .TIMEOUT_CLKS(50),
        .STALE_CLKS  (500)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_RX_DV      (rx_dv),
        .i_RX_Byte    (rx_byte),
        .o_Yaw        (yaw),
        .o_Roll       (roll),
        .o_Pitch      (pitch),
        .o_Frame_Valid(fv),
        .o_Err_Count  (err),
        .o_Stale      (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_dv = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic body(input logic [15:0] y, input logic [15:0] r, input logic [15:0] p);
        send(y[15:8]); send(y[7:0]); send(8'h20);
        send(r[15:8]); send(r[7:0]); send(8'h20);
        send(p[15:8]); send(p[7:0]); send(8'h0A);
        rx_dv = 1'b0;
    endtask

    task automatic expect_frame(input logic [15:0] y, input logic [15:0] r, input logic [15:0] p);
        exp_t e;
        e.y = y; e.r = r; e.p = p; e.e = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [15:0] y, input logic [15:0] r, input logic [15:0] p);
        expect_frame(y, r, p);
        send(8'h53);
        body(y, r, p);
    endtask

    always @(negedge clk) begin
        if (fv) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame_valid: got pulse expected none (yaw %0h)", yaw);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_yaw",   {16'd0, yaw},   {16'd0, e.y});
                chk("frame_roll",  {16'd0, roll},  {16'd0, e.r});
                chk("frame_pitch", {16'd0, pitch}, {16'd0, e.p});
                chk("frame_err",   {24'd0, err},   {24'd0, e.e});
                chk("frame_stale", {31'd0, stale}, 32'd0);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_err  = 8'd0;
        rst_l    = 1'b0;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_yaw",   {16'd0, yaw},   32'd0);
        chk("rst_roll",  {16'd0, roll},  32'd0);
        chk("rst_pitch", {16'd0, pitch}, 32'd0);
        chk("rst_err",   {24'd0, err},   32'd0);
        chk("rst_stale", {31'd0, stale}, 32'd1);
        chk("rst_fv",    {31'd0, fv},    32'd0);
        rst_l = 1'b1;
        idle(2);

        // Basic frame and frame with marker values in data slots
        frame(16'h0168, 16'hFF38, 16'h00B4);
        idle(3);
        chk("t1_err", {24'd0, err}, 32'd0);
        frame(16'h530A, 16'h2053, 16'h0A0A);
        idle(3);
        chk("t2_err", {24'd0, err}, 32'd0);

        // Bad separator, not a sync byte: abort then a good frame
        send(8'h53); send(8'h01); send(8'h02); send(8'h41);
        idle(2);
        exp_err = 8'd1;
        chk("t3_err",       {24'd0, err}, {24'd0, exp_err});
        chk("t3_yaw_kept",  {16'd0, yaw}, 32'h0000530A);
        frame(16'h1234, 16'h5678, 16'h9ABC);
        idle(3);

        // Bad separator that is a sync byte: resync in place
        send(8'h53); send(8'h01); send(8'h02);
        exp_err = 8'd2;
        expect_frame(16'hBEEF, 16'h8001, 16'h7FFF);
        send(8'h53);
        body(16'hBEEF, 16'h8001, 16'h7FFF);
        idle(3);
        chk("t4_err", {24'd0, err}, {24'd0, exp_err});

        // Inter-byte timeout aborts; outputs hold
        send(8'h53); send(8'h01); send(8'h02);
        idle(60);
        exp_err = 8'd3;
        chk("t5_err",        {24'd0, err},   {24'd0, exp_err});
        chk("t5_yaw_kept",   {16'd0, yaw},   32'h0000BEEF);
        chk("t5_pitch_kept", {16'd0, pitch}, 32'h00007FFF);
        frame(16'h0001, 16'h0002, 16'h0003);
        idle(3);

        // Each byte arrives exactly on the timeout cycle: byte wins every time
        expect_frame(16'hCAFE, 16'h0F0F, 16'hF00D);
        send(8'h53);
        begin
            logic [7:0] seq [9];
            seq = '{8'hCA, 8'hFE, 8'h20, 8'h0F, 8'h0F, 8'h20, 8'hF0, 8'h0D, 8'h0A};
            for (int i = 0; i < 9; i++) begin
                idle(49);
                send(seq[i]);
            end
        end
        rx_dv = 1'b0;
        chk("t5b_err_boundary", {24'd0, err}, {24'd0, exp_err});

        // Stale after 500 idle clocks from the last good frame
        idle(480);
        chk("t6_stale_before", {31'd0, stale}, 32'd0);
        idle(30);
        chk("t6_stale_after", {31'd0, stale}, 32'd1);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            send(8'h53); send(8'h00); send(8'h00); send(8'h41);
        end
        idle(2);
        exp_err = 8'hFF;
        chk("t6_err_sat", {24'd0, err}, 32'h000000FF);

        // Reset mid-frame
        send(8'h53); send(8'h01); send(8'h02);
        rx_dv = 1'b0;
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        chk("mrst_yaw",   {16'd0, yaw},   32'd0);
        chk("mrst_roll",  {16'd0, roll},  32'd0);
        chk("mrst_pitch", {16'd0, pitch}, 32'd0);
        chk("mrst_err",   {24'd0, err},   32'd0);
        chk("mrst_stale", {31'd0, stale}, 32'd1);
        exp_err = 8'd0;
        send(8'h20); send(8'h21);
        idle(2);
        chk("mrst_hunt_err", {24'd0, err}, 32'd0);
        frame(16'h4321, 16'h1111, 16'h2222);
        frame(16'h0BAD, 16'hD00D, 16'h0042);
        idle(5);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
